// File: rtl/conv3x3_frame_sequencer.sv
// Frame sequencer for the 3x3 stride-1 merge conv engine: streams D*D source reads,
// captures (D-2)^2 merged results, reports done or a drain timeout.
module conv3x3_frame_sequencer #(
  parameter  int D          = 9,
  parameter  int DATA_WIDTH = 32,
  parameter  int TIMEOUT    = 64,
  localparam int T          = D * D,
  localparam int OUT_N      = (D - 2) * (D - 2),
  localparam int AW         = $clog2(T),
  localparam int OW         = $clog2(OUT_N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic          src_ready,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  output logic          conv_flush,
  output logic          conv_valid_in,
  input  logic          conv_valid_out,
  output logic          out_wr_en,
  output logic [OW-1:0] out_addr,
  output logic          busy,
  output logic          done,
  output logic          err_timeout
);

  // Output counter must hold OUT_N itself, not just the last address.
  localparam int CW = $clog2(OUT_N + 1);
  localparam int IW = $clog2(TIMEOUT + 1);

  if (DATA_WIDTH < 1 || D < 3) begin : g_bad_params
    $error("conv3x3_frame_sequencer: unsupported D/DATA_WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLUSH = 2'd1,
    S_FEED  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          vin_q, vin_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          rd_fire;
  logic          wr_fire;
  logic          out_room;

  assign out_room = (out_cnt_q < CW'(OUT_N));
  assign rd_fire  = (state_q == S_FEED) && src_ready && !abort;
  assign wr_fire  = ((state_q == S_FEED) || (state_q == S_DRAIN)) && conv_valid_out
                    && out_room && !abort;

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    out_cnt_d = out_cnt_q;
    idle_d    = idle_q;
    err_d     = err_q;
    done_d    = 1'b0;
    vin_d     = rd_fire;

    if (wr_fire) out_cnt_d = out_cnt_q + 1'b1;

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d   = S_FLUSH;
            rd_addr_d = '0;
            out_cnt_d = '0;
            idle_d    = '0;
            err_d     = 1'b0;
          end
        end
        S_FLUSH: state_d = S_FEED;
        S_FEED: begin
          if (rd_fire) begin
            if (rd_addr_q == AW'(T - 1)) begin
              rd_addr_d = '0;
              state_d   = S_DRAIN;
            end else begin
              rd_addr_d = rd_addr_q + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          idle_d = conv_valid_out ? '0 : idle_q + 1'b1;
          // Completion is checked first so a last write on the timeout cycle still counts.
          if (out_cnt_d == CW'(OUT_N)) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else if (idle_d == IW'(TIMEOUT)) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      rd_addr_q <= '0;
      out_cnt_q <= '0;
      idle_q    <= '0;
      vin_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      out_cnt_q <= out_cnt_d;
      idle_q    <= idle_d;
      vin_q     <= vin_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign rd_en         = rd_fire;
  assign rd_addr       = rd_addr_q;
  assign conv_flush    = (state_q == S_FLUSH);
  assign conv_valid_in = vin_q && !abort;
  assign out_wr_en     = wr_fire;
  assign out_addr      = out_room ? out_cnt_q[OW-1:0] : OW'(OUT_N - 1);
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign err_timeout   = err_q;

endmodule
